// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - Single-port SRAM responder with fixed access latency.
// Optional power-up clear sequence under macro SRAM_RESPONDER_CLEAR_EN.
module sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        gnt,
    output logic        hrd,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        ready
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_BUSY = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [31:0]         spo_q, spo_d;
    logic                op_we_q, op_we_d;
    logic                op_rd_q, op_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
`ifdef SRAM_RESPONDER_CLEAR_EN
    logic                hrd_q, hrd_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
`endif

    logic [31:0]         mem_q [2**ADDR_W];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;

    logic                commit;
    logic                c_we, c_rd;
    logic [ADDR_W-1:0]   c_addr;
    logic [31:0]         c_data;

    logic                unused_a;
    assign unused_a = ^{a[31:ADDR_W+2], a[1:0]};

`ifdef SRAM_RESPONDER_CLEAR_EN
    assign hrd = hrd_q;
`else
    assign hrd = 1'b0;
`endif
    assign gnt   = req & ~hrd;
    assign spo   = spo_q;
    assign ready = ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = 1'b0;
        spo_d     = spo_q;
        op_we_d   = op_we_q;
        op_rd_d   = op_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef SRAM_RESPONDER_CLEAR_EN
        hrd_d     = hrd_q;
        clr_d     = clr_q;
`endif
        commit    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = 32'd0;

        // With LATENCY=1 the accept edge is also the commit edge, so use live bus values.
        if (state_q == S_IDLE) begin
            c_we   = we;
            c_rd   = rd & ~we;
            c_addr = a[ADDR_W+1:2];
            c_data = d;
        end else begin
            c_we   = op_we_q;
            c_rd   = op_rd_q;
            c_addr = addr_q;
            c_data = wdata_q;
        end

        case (state_q)
            S_INIT: begin
`ifdef SRAM_RESPONDER_CLEAR_EN
                mem_we    = 1'b1;
                mem_addr  = clr_q;
                mem_wdata = 32'd0;
                clr_d     = clr_q + ADDR_W'(1);
                if (clr_q == '1) begin
                    state_d = S_IDLE;
                    hrd_d   = 1'b0;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_IDLE: begin
                if (gnt && (rd || we)) begin
                    op_we_d = we;
                    op_rd_d = rd & ~we;
                    addr_d  = a[ADDR_W+1:2];
                    wdata_d = d;
                    if (LATENCY > 1) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            ready_d   = 1'b1;
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = swap32(c_data);
            if (c_rd) begin
                spo_d = swap32(mem_q[c_addr]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef SRAM_RESPONDER_CLEAR_EN
            state_q <= S_INIT;
            hrd_q   <= 1'b1;
            clr_q   <= '0;
`else
            state_q <= S_IDLE;
`endif
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            spo_q   <= 32'd0;
            op_we_q <= 1'b0;
            op_rd_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
`ifdef SRAM_RESPONDER_CLEAR_EN
            hrd_q   <= hrd_d;
            clr_q   <= clr_d;
`endif
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            spo_q   <= spo_d;
            op_we_q <= op_we_d;
            op_rd_q <= op_rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Storage is deliberately outside the reset domain; only INIT clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - Directed and random checks of sram_responder against a word-level model.
module tb_sram_responder;

`ifdef SRAM_RESPONDER_CLEAR_EN
    localparam int AW = 4;
`else
    localparam int AW = 10;
`endif
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        gnt, hrd;
    logic [31:0] a = 32'd0;
    logic [31:0] d = 32'd0;
    logic        we = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] spo;
    logic        ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [int];
    logic [31:0] exp_spo = 32'd0;

    always #5 clk = ~clk;

    sram_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .hrd(hrd),
        .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr / 4) % (2 ** AW);
    endfunction

    task automatic access(input string tag, input bit do_rd, input bit do_we,
                          input logic [31:0] addr, input logic [31:0] data, input bit extra_rd);
        int lat;
        int pulses;
        lat = 0;
        pulses = 0;
        req = 1'b1; rd = do_rd; we = do_we; a = addr; d = data;
        chk({tag, ".gnt"}, 32'(gnt), 32'd1);
        tick();
        rd = 1'b0; we = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            if (ready === 1'b1) begin
                pulses++;
                if (lat == 0) lat = k;
            end
            rd = (extra_rd && k == 1);
            if (k < LAT + 3) tick();
        end
        rd = 1'b0;
        req = 1'b0;
        if (do_we) mdl[word_of(addr)] = data;
        else if (do_rd) exp_spo = mdl[word_of(addr)];
        chk({tag, ".latency"}, 32'(lat), 32'(LAT));
        chk({tag, ".pulses"}, 32'(pulses), 32'd1);
        chk({tag, ".spo"}, spo, exp_spo);
    endtask

    task automatic post_reset();
`ifdef SRAM_RESPONDER_CLEAR_EN
        req = 1'b1;
        for (int i = 0; i < 2 ** AW; i++) begin
            chk("init.hrd", 32'(hrd), 32'd1);
            chk("init.gnt", 32'(gnt), 32'd0);
            chk("init.ready", 32'(ready), 32'd0);
            rd = (i < 3);
            tick();
        end
        rd = 1'b0;
        chk("init_done.hrd", 32'(hrd), 32'd0);
        chk("init_done.gnt", 32'(gnt), 32'd1);
        chk("init_done.ready", 32'(ready), 32'd0);
        req = 1'b0;
        mdl.delete();
        for (int w = 0; w < 2 ** AW; w++) mdl[w] = 32'd0;
`else
        req = 1'b1;
        chk("idle.hrd", 32'(hrd), 32'd0);
        chk("idle.gnt", 32'(gnt), 32'd1);
        req = 1'b0;
        chk("idle.gnt_noreq", 32'(gnt), 32'd0);
`endif
    endtask

    initial begin
        int pulses;
        int base [8];
        logic [31:0] rnd_a;
        logic [31:0] rnd_d;

        #2 rst_n = 1'b0;
        #1;
        chk("reset.ready", 32'(ready), 32'd0);
        chk("reset.spo", spo, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        post_reset();

        access("wr10", 1'b0, 1'b1, 32'h10, 32'h11223344, 1'b0);
        access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("rd10.value", spo, 32'h11223344);
        access("rd1013", 1'b1, 1'b0, 32'h1013, 32'h0, 1'b0);
        chk("rd1013.value", spo, 32'h11223344);
        access("rd1010", 1'b1, 1'b0, 32'h1010, 32'h0, 1'b0);
        chk("rd1010.value", spo, 32'h11223344);

        access("rdwe0", 1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0);
        chk("rdwe0.spo_held", spo, 32'h11223344);
        access("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rd0.value", spo, 32'hDEADBEEF);

        access("rd_busy", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);

        // Strobe without req must not start an access.
        req = 1'b0; rd = 1'b1; a = 32'h10;
        tick();
        rd = 1'b0;
        pulses = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            if (ready === 1'b1) pulses++;
            tick();
        end
        chk("noreq.pulses", 32'(pulses), 32'd0);

        for (int i = 0; i < 8; i++) begin
            base[i] = int'($urandom_range(0, 2 ** AW - 1));
            access("fill", 1'b0, 1'b1, 32'(base[i]) << 2, $urandom, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            rnd_a = (32'(base[$urandom_range(0, 7)]) << 2) | ($urandom & 32'h3)
                    | (($urandom & 32'h3) << (AW + 2));
            rnd_d = $urandom;
            case ($urandom_range(0, 3))
                0:       access("rnd_wr", 1'b0, 1'b1, rnd_a, rnd_d, 1'b0);
                1:       access("rnd_rdwe", 1'b1, 1'b1, rnd_a, rnd_d, 1'b0);
                default: access("rnd_rd", 1'b1, 1'b0, rnd_a, rnd_d, $urandom_range(0, 1) == 1);
            endcase
        end

        access("pre_rst_wr", 1'b0, 1'b1, 32'h10, 32'hA5A55A5A, 1'b0);
        req = 1'b1; we = 1'b1; a = 32'h10; d = 32'hCAFEF00D;
        tick();
        we = 1'b0; req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort.ready", 32'(ready), 32'd0);
        chk("abort.spo", spo, 32'd0);
        exp_spo = 32'd0;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            if (ready === 1'b1) pulses++;
            if (k < LAT + 1) tick();
        end
        chk("abort.pulses", 32'(pulses), 32'd0);
`ifdef SRAM_RESPONDER_CLEAR_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`endif
        post_reset();
        access("post_abort_rd", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
`ifdef SRAM_RESPONDER_CLEAR_EN
        chk("post_abort.value", spo, 32'h0);
        access("cleared_rd", 1'b1, 1'b0, 32'h3C, 32'h0, 1'b0);
        chk("cleared.value", spo, 32'h0);
`else
        chk("post_abort.value", spo, 32'hA5A55A5A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width (2^ADDR_W 32-bit words, 4 KiB at default).
REQ-002 Parameter LATENCY, default 2, cycles from request cycle to ready cycle; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  1  initiator requests bus ownership.
REQ-006 gnt  output  1  bus granted to initiator.
REQ-007 hrd  output  1  responder hold: initiator shall not issue accesses while high.
REQ-008 a  input  32  byte address; a[1:0] ignored, a[ADDR_W+1:2] selects word, upper bits alias.
REQ-009 d  input  32  write data, bus lane order (byte 0 in d[31:24]).
REQ-010 we  input  1  write strobe, one-cycle pulse.
REQ-011 rd  input  1  read strobe, one-cycle pulse.
REQ-012 spo  output  32  read data, bus lane order.
REQ-013 ready  output  1  one-cycle completion pulse.

Function
REQ-014 gnt SHALL equal req & !hrd, combinational.
REQ-015 States SHALL be INIT, IDLE, BUSY, RESP.
REQ-016 IDLE: access accepted in any cycle with gnt & (rd | we); a, d, rd, we latched that edge; next state BUSY if LATENCY>1, else RESP.
REQ-017 BUSY: down-counter loaded with LATENCY-2 at accept; rd/we ignored; enter RESP when counter is 0.
REQ-018 RESP: ready=1 for exactly one cycle, then IDLE; rd/we during RESP ignored (not queued).
REQ-019 ready SHALL assert exactly LATENCY cycles after the request cycle.
REQ-020 Memory stores little-endian; write stores byte-swap of d; read drives byte-swap of stored word, so bus-side write/read round trip is identity.
REQ-021 Write SHALL commit on the edge entering RESP; read data SHALL be loaded into spo on that same edge.
REQ-022 rd and we together: write only; spo unchanged.
REQ-023 spo SHALL hold last read data until next read response, including across writes.
REQ-024 hrd SHALL be 0 in IDLE, BUSY, RESP; accesses presented while hrd=1 SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force ready=0, spo=0, counter=0, state to INIT (macro on) or IDLE (macro off).
REQ-026 Reset during BUSY SHALL abort the access: no write committed, no ready pulse.
REQ-027 Memory contents SHALL NOT be cleared by reset except via the INIT sequence.

Configuration
REQ-028 Macro SRAM_RESPONDER_CLEAR_EN defined: after reset, INIT writes 0 to every word, one word per cycle from word 0 upward, hrd=1 throughout; exactly 2^ADDR_W cycles in INIT, then IDLE.
REQ-029 Macro undefined: no INIT state, hrd tied 0, memory powers up undefined, reset goes straight to IDLE.

Verification
REQ-030 LATENCY=2: write d=32'h11223344 to a=32'h10; read a=32'h10 -> ready exactly 2 cycles after each request; spo=32'h11223344.
REQ-031 Read a=32'h10 and a=32'h1013 after REQ-030 -> a[1:0] ignored, both spo=32'h11223344; a=32'h1010 at ADDR_W=10 aliases to word 4.
REQ-032 rd=1 and we=1 with d=32'hDEADBEEF, a=0 -> ready after LATENCY, spo unchanged, later read a=0 returns 32'hDEADBEEF.
REQ-033 Second rd pulse during BUSY -> ignored, exactly one ready pulse.
REQ-034 rst_n low one cycle after write accept, LATENCY=3 -> no ready, later read shows old word contents.
REQ-035 Macro defined, ADDR_W=4: after reset release hrd=1 and gnt=0 for 16 cycles with req=1, then hrd=0, gnt=1; read of any word -> spo=0.
